// File: rtl/ctrl_mem_arbiter_if.sv
// Bundles the host and controller request/response channels, the controller lock
// and the single BRAM port shared by ctrl_mem_arbiter.
interface ctrl_mem_arbiter_if #(
  parameter int MEM_ADDR_WIDTH = 9
);
  logic                      host_req_valid;
  logic                      host_req_ready;
  logic                      host_req_we;
  logic [MEM_ADDR_WIDTH-1:0] host_req_addr;
  logic [63:0]               host_req_wdata;
  logic                      host_rsp_valid;
  logic [63:0]               host_rsp_rdata;

  logic                      ctrl_req_valid;
  logic                      ctrl_req_ready;
  logic                      ctrl_req_we;
  logic [MEM_ADDR_WIDTH-1:0] ctrl_req_addr;
  logic [63:0]               ctrl_req_wdata;
  logic                      ctrl_rsp_valid;
  logic [63:0]               ctrl_rsp_rdata;
  logic                      ctrl_lock;

  logic                      mem_we;
  logic [MEM_ADDR_WIDTH-1:0] mem_addr;
  logic [63:0]               mem_din;
  logic [63:0]               mem_dout;

  // Arbiter side.
  modport slave (
    input  host_req_valid, host_req_we, host_req_addr, host_req_wdata,
    output host_req_ready, host_rsp_valid, host_rsp_rdata,
    input  ctrl_req_valid, ctrl_req_we, ctrl_req_addr, ctrl_req_wdata, ctrl_lock,
    output ctrl_req_ready, ctrl_rsp_valid, ctrl_rsp_rdata,
    output mem_we, mem_addr, mem_din,
    input  mem_dout
  );

  // Requester and memory side.
  modport master (
    output host_req_valid, host_req_we, host_req_addr, host_req_wdata,
    input  host_req_ready, host_rsp_valid, host_rsp_rdata,
    output ctrl_req_valid, ctrl_req_we, ctrl_req_addr, ctrl_req_wdata, ctrl_lock,
    input  ctrl_req_ready, ctrl_rsp_valid, ctrl_rsp_rdata,
    input  mem_we, mem_addr, mem_din,
    output mem_dout
  );
endinterface

// File: rtl/ctrl_mem_arbiter.sv
// Round-robin arbiter sharing one 64-bit control-memory port between host and controller.
// Optional counters stat_conflicts/stat_host_stall are built when CTRL_MEM_ARB_STATS_EN is defined.
module ctrl_mem_arbiter #(
  parameter int MEM_ADDR_WIDTH   = 9,
  parameter int MEM_READ_LATENCY = 2
) (
  input  logic               clk,
  input  logic               rst,
  ctrl_mem_arbiter_if.slave  bus
`ifdef CTRL_MEM_ARB_STATS_EN
  ,
  output logic [31:0]        stat_conflicts,
  output logic [31:0]        stat_host_stall
`endif
);

  localparam logic [0:0] REQ_HOST = 1'b0;
  localparam logic [0:0] REQ_CTRL = 1'b1;
  localparam int         TAG_W    = 2;

  logic [0:0]                rr_last_q, rr_last_d;
  logic                      grant_host, grant_ctrl;
  logic                      accept_read;
  logic [MEM_ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [63:0]               mem_din_q, mem_din_d;

  // Tag word: bit 1 = read in flight, bit 0 = requester.
  logic [TAG_W-1:0]          tag_in;
  logic [TAG_W-1:0]          tag_q [MEM_READ_LATENCY];
  logic [TAG_W-1:0]          tag_d [MEM_READ_LATENCY];
  logic [TAG_W-1:0]          tag_out;

  logic                      host_rsp_valid_q, host_rsp_valid_d;
  logic                      ctrl_rsp_valid_q, ctrl_rsp_valid_d;
  logic [63:0]               host_rsp_rdata_q, host_rsp_rdata_d;
  logic [63:0]               ctrl_rsp_rdata_q, ctrl_rsp_rdata_d;

  // Grant is purely combinational; the lock overrides round-robin the cycle it rises.
  always_comb begin
    grant_host = 1'b0;
    grant_ctrl = 1'b0;
    if (!rst) begin
      if (bus.ctrl_lock) begin
        grant_ctrl = bus.ctrl_req_valid;
      end else if (bus.host_req_valid && bus.ctrl_req_valid) begin
        grant_host = (rr_last_q != REQ_HOST);
        grant_ctrl = (rr_last_q == REQ_HOST);
      end else begin
        grant_host = bus.host_req_valid;
        grant_ctrl = bus.ctrl_req_valid;
      end
    end
  end

  always_comb begin
    rr_last_d   = rr_last_q;
    mem_addr_d  = mem_addr_q;
    mem_din_d   = mem_din_q;
    accept_read = 1'b0;
    tag_in      = '0;
    if (grant_host) begin
      rr_last_d   = REQ_HOST;
      mem_addr_d  = bus.host_req_addr;
      mem_din_d   = bus.host_req_wdata;
      accept_read = !bus.host_req_we;
      tag_in      = {!bus.host_req_we, REQ_HOST};
    end else if (grant_ctrl) begin
      rr_last_d   = REQ_CTRL;
      mem_addr_d  = bus.ctrl_req_addr;
      mem_din_d   = bus.ctrl_req_wdata;
      accept_read = !bus.ctrl_req_we;
      tag_in      = {!bus.ctrl_req_we, REQ_CTRL};
    end
  end

  assign bus.host_req_ready = grant_host;
  assign bus.ctrl_req_ready = grant_ctrl;
  assign bus.mem_we   = (grant_host && bus.host_req_we) || (grant_ctrl && bus.ctrl_req_we);
  assign bus.mem_addr = rst ? '0 : mem_addr_d;
  assign bus.mem_din  = rst ? '0 : mem_din_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_last_q  <= REQ_CTRL;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
    end else begin
      rr_last_q  <= rr_last_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
    end
  end

  // Tag shift register tracks each accepted read until its BRAM data is valid.
  genvar gi;
  generate
    for (gi = 0; gi < MEM_READ_LATENCY; gi++) begin : g_tag
      if (gi == 0) begin : g_head
        assign tag_d[gi] = tag_in;
      end else begin : g_body
        assign tag_d[gi] = tag_q[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MEM_READ_LATENCY; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      tag_q <= tag_d;
    end
  end

  assign tag_out = tag_q[MEM_READ_LATENCY-1];

  always_comb begin
    host_rsp_valid_d = tag_out[1] && (tag_out[0] == REQ_HOST);
    ctrl_rsp_valid_d = tag_out[1] && (tag_out[0] == REQ_CTRL);
    host_rsp_rdata_d = host_rsp_valid_d ? bus.mem_dout : host_rsp_rdata_q;
    ctrl_rsp_rdata_d = ctrl_rsp_valid_d ? bus.mem_dout : ctrl_rsp_rdata_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      host_rsp_valid_q <= 1'b0;
      ctrl_rsp_valid_q <= 1'b0;
      host_rsp_rdata_q <= '0;
      ctrl_rsp_rdata_q <= '0;
    end else begin
      host_rsp_valid_q <= host_rsp_valid_d;
      ctrl_rsp_valid_q <= ctrl_rsp_valid_d;
      host_rsp_rdata_q <= host_rsp_rdata_d;
      ctrl_rsp_rdata_q <= ctrl_rsp_rdata_d;
    end
  end

  // Responses already in the output register are suppressed while reset is held.
  assign bus.host_rsp_valid = host_rsp_valid_q && !rst;
  assign bus.ctrl_rsp_valid = ctrl_rsp_valid_q && !rst;
  assign bus.host_rsp_rdata = rst ? '0 : host_rsp_rdata_q;
  assign bus.ctrl_rsp_rdata = rst ? '0 : ctrl_rsp_rdata_q;

`ifdef CTRL_MEM_ARB_STATS_EN
  logic [31:0] stat_conflicts_q, stat_conflicts_d;
  logic [31:0] stat_host_stall_q, stat_host_stall_d;

  always_comb begin
    stat_conflicts_d  = stat_conflicts_q;
    stat_host_stall_d = stat_host_stall_q;
    if (bus.host_req_valid && bus.ctrl_req_valid && (stat_conflicts_q != 32'hFFFF_FFFF)) begin
      stat_conflicts_d = stat_conflicts_q + 32'd1;
    end
    if (bus.host_req_valid && !grant_host && (stat_host_stall_q != 32'hFFFF_FFFF)) begin
      stat_host_stall_d = stat_host_stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_conflicts_q  <= '0;
      stat_host_stall_q <= '0;
    end else begin
      stat_conflicts_q  <= stat_conflicts_d;
      stat_host_stall_q <= stat_host_stall_d;
    end
  end

  assign stat_conflicts  = stat_conflicts_q;
  assign stat_host_stall = stat_host_stall_q;
`endif

endmodule

// File: tb/tb_ctrl_mem_arbiter.sv
// Self-checking bench for ctrl_mem_arbiter: vector table for grants plus a read-response scoreboard.
module tb_ctrl_mem_arbiter;
  localparam int AW  = 9;
  localparam int LAT = 2;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ctrl_mem_arbiter_if #(.MEM_ADDR_WIDTH(AW)) bus ();

`ifdef CTRL_MEM_ARB_STATS_EN
  logic [31:0] stat_conflicts;
  logic [31:0] stat_host_stall;
`endif

  ctrl_mem_arbiter #(.MEM_ADDR_WIDTH(AW), .MEM_READ_LATENCY(LAT)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef CTRL_MEM_ARB_STATS_EN
    ,
    .stat_conflicts(stat_conflicts),
    .stat_host_stall(stat_host_stall)
`endif
  );

  function automatic logic [63:0] init_word(input int i);
    if (i == 16) return 64'h1122_3344_5566_7788;
    return {32'h5A5A_0000 + 32'(i), 32'hC0DE_0000 + 32'(i)};
  endfunction

  // Write-first BRAM model with LAT cycles of read latency.
  logic [63:0] mem_arr [DEPTH];
  logic [63:0] rd_pipe [LAT];
  bit          mem_init_done = 1'b0;
  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < DEPTH; i++) mem_arr[i] <= init_word(i);
      mem_init_done <= 1'b1;
    end else begin
      if (bus.mem_we) mem_arr[bus.mem_addr] <= bus.mem_din;
      rd_pipe[0] <= bus.mem_we ? bus.mem_din : mem_arr[bus.mem_addr];
      for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
  end
  assign bus.mem_dout = rd_pipe[LAT-1];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk1(input string name, input logic got, input logic exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0b expected %0b (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic chkw(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Scoreboard: accepted reads push an expected response, outputs pop and compare.
  typedef struct {
    logic        req;
    logic [63:0] data;
    int          due;
  } exp_t;
  exp_t        sb_q [$];
  logic [63:0] ref_mem [DEPTH];
  bit          ref_init_done = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (!ref_init_done) begin
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
      ref_init_done = 1'b1;
    end
    if (rst) begin
      sb_q.delete();
    end else begin
      if (bus.host_rsp_valid || bus.ctrl_rsp_valid) begin
        n_cmp++;
        if (bus.host_rsp_valid && bus.ctrl_rsp_valid) begin
          n_bad++;
          $display("FAIL rsp_both: host and ctrl responses in the same cycle %0d", cyc);
        end else if (sb_q.size() == 0) begin
          n_bad++;
          $display("FAIL rsp_unexpected: host=%0b ctrl=%0b with no read pending (cycle %0d)",
                   bus.host_rsp_valid, bus.ctrl_rsp_valid, cyc);
        end else begin
          e = sb_q.pop_front();
          if (e.req !== bus.ctrl_rsp_valid || e.due != cyc ||
              e.data !== (bus.ctrl_rsp_valid ? bus.ctrl_rsp_rdata : bus.host_rsp_rdata)) begin
            n_bad++;
            $display("FAIL rsp: got req=%0b data=%h cycle %0d expected req=%0b data=%h cycle %0d",
                     bus.ctrl_rsp_valid,
                     bus.ctrl_rsp_valid ? bus.ctrl_rsp_rdata : bus.host_rsp_rdata,
                     cyc, e.req, e.data, e.due);
          end else begin
            $display("rsp req=%0b data=%h cycle %0d ok", e.req, e.data, cyc);
          end
        end
      end
      if (sb_q.size() > 0 && sb_q[0].due < cyc) begin
        n_cmp++;
        n_bad++;
        $display("FAIL rsp_missing: got none expected req=%0b data=%h at cycle %0d",
                 sb_q[0].req, sb_q[0].data, sb_q[0].due);
        void'(sb_q.pop_front());
      end
      if (bus.host_req_valid && bus.host_req_ready) begin
        if (bus.host_req_we) ref_mem[bus.host_req_addr] = bus.host_req_wdata;
        else sb_q.push_back('{1'b0, ref_mem[bus.host_req_addr], cyc + LAT + 1});
      end
      if (bus.ctrl_req_valid && bus.ctrl_req_ready) begin
        if (bus.ctrl_req_we) ref_mem[bus.ctrl_req_addr] = bus.ctrl_req_wdata;
        else sb_q.push_back('{1'b1, ref_mem[bus.ctrl_req_addr], cyc + LAT + 1});
      end
    end
  end

  task automatic drive(input logic hv, input logic hwe, input logic [AW-1:0] ha,
                       input logic [63:0] hwd, input logic cv, input logic cwe,
                       input logic [AW-1:0] ca, input logic [63:0] cwd, input logic lk);
    @(posedge clk);
    #1;
    bus.host_req_valid = hv;
    bus.host_req_we    = hwe;
    bus.host_req_addr  = ha;
    bus.host_req_wdata = hwd;
    bus.ctrl_req_valid = cv;
    bus.ctrl_req_we    = cwe;
    bus.ctrl_req_addr  = ca;
    bus.ctrl_req_wdata = cwd;
    bus.ctrl_lock      = lk;
    @(negedge clk);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk1({tag, "_host_ready"}, bus.host_req_ready, 1'b0);
    chk1({tag, "_ctrl_ready"}, bus.ctrl_req_ready, 1'b0);
    chk1({tag, "_host_rsp_valid"}, bus.host_rsp_valid, 1'b0);
    chk1({tag, "_ctrl_rsp_valid"}, bus.ctrl_rsp_valid, 1'b0);
    chkw({tag, "_host_rdata"}, bus.host_rsp_rdata, 64'h0);
    chkw({tag, "_ctrl_rdata"}, bus.ctrl_rsp_rdata, 64'h0);
    chk1({tag, "_mem_we"}, bus.mem_we, 1'b0);
    chkw({tag, "_mem_addr"}, 64'(bus.mem_addr), 64'h0);
    chkw({tag, "_mem_din"}, bus.mem_din, 64'h0);
  endtask

  typedef struct {
    logic          hv, hwe;
    logic [AW-1:0] ha;
    logic [63:0]   hwd;
    logic          cv, cwe;
    logic [AW-1:0] ca;
    logic [63:0]   cwd;
    logic          lock;
    logic          e_hr, e_cr, e_mwe;
    logic [AW-1:0] e_maddr;
    logic [63:0]   e_mdin;
  } vec_t;

  localparam logic [63:0] HW  = 64'h0101_0101_0101_0101;
  localparam logic [63:0] CW  = 64'h0202_0202_0202_0202;
  localparam logic [63:0] H1  = 64'h0BAD_F00D_1234_5678;
  localparam logic [63:0] CWR = 64'hCAFE_0000_0000_0020;
  localparam logic [63:0] DB  = 64'h0000_0000_DEAD_BEEF;

  vec_t vecs [14];

  initial begin
    rst = 1'b1;
    // Valid writes during reset must not reach the memory or be acknowledged.
    bus.host_req_valid = 1'b1; bus.host_req_we = 1'b1; bus.host_req_addr = 9'h055;
    bus.host_req_wdata = 64'hFFFF; bus.ctrl_req_valid = 1'b1; bus.ctrl_req_we = 1'b1;
    bus.ctrl_req_addr = 9'h066; bus.ctrl_req_wdata = 64'hEEEE; bus.ctrl_lock = 1'b0;

    //        hv    hwe   ha      hwd  cv    cwe   ca      cwd  lock  hr    cr    mwe   maddr   mdin
    vecs[0]  = '{1'b1, 1'b0, 9'h010, 64'h0, 1'b0, 1'b0, 9'h000, 64'h0, 1'b0, 1'b1, 1'b0, 1'b0, 9'h010, 64'h0};
    vecs[1]  = '{1'b0, 1'b0, 9'h000, 64'h0, 1'b0, 1'b0, 9'h000, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0, 9'h010, 64'h0};
    vecs[2]  = vecs[1];
    vecs[3]  = vecs[1];
    vecs[4]  = '{1'b0, 1'b0, 9'h000, 64'h0, 1'b1, 1'b1, 9'h020, CWR,   1'b0, 1'b0, 1'b1, 1'b1, 9'h020, CWR};
    vecs[5]  = '{1'b1, 1'b0, 9'h030, HW,    1'b1, 1'b0, 9'h040, CW,    1'b0, 1'b1, 1'b0, 1'b0, 9'h030, HW};
    vecs[6]  = '{1'b1, 1'b0, 9'h030, HW,    1'b1, 1'b0, 9'h040, CW,    1'b0, 1'b0, 1'b1, 1'b0, 9'h040, CW};
    vecs[7]  = vecs[5];
    vecs[8]  = vecs[6];
    vecs[9]  = vecs[5];
    vecs[10] = vecs[6];
    vecs[11] = '{1'b1, 1'b1, 9'h030, H1,    1'b1, 1'b0, 9'h030, CW,    1'b0, 1'b1, 1'b0, 1'b1, 9'h030, H1};
    vecs[12] = '{1'b0, 1'b0, 9'h000, 64'h0, 1'b1, 1'b0, 9'h030, CW,    1'b0, 1'b0, 1'b1, 1'b0, 9'h030, CW};
    vecs[13] = '{1'b0, 1'b0, 9'h000, 64'h0, 1'b0, 1'b0, 9'h000, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0, 9'h030, CW};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("init_reset");
`ifdef CTRL_MEM_ARB_STATS_EN
    chkw("init_stat_conflicts", 64'(stat_conflicts), 64'd0);
    chkw("init_stat_host_stall", 64'(stat_host_stall), 64'd0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.host_req_valid = 1'b0;
    bus.ctrl_req_valid = 1'b0;

    // Single host read, idle, then alternating grants under conflict.
    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].hv, vecs[i].hwe, vecs[i].ha, vecs[i].hwd,
            vecs[i].cv, vecs[i].cwe, vecs[i].ca, vecs[i].cwd, vecs[i].lock);
      $display("vec %0d: hr=%0b cr=%0b we=%0b addr=%h", i, bus.host_req_ready,
               bus.ctrl_req_ready, bus.mem_we, bus.mem_addr);
      chk1($sformatf("v%0d_host_ready", i), bus.host_req_ready, vecs[i].e_hr);
      chk1($sformatf("v%0d_ctrl_ready", i), bus.ctrl_req_ready, vecs[i].e_cr);
      chk1($sformatf("v%0d_mem_we", i), bus.mem_we, vecs[i].e_mwe);
      chkw($sformatf("v%0d_mem_addr", i), 64'(bus.mem_addr), 64'(vecs[i].e_maddr));
      chkw($sformatf("v%0d_mem_din", i), bus.mem_din, vecs[i].e_mdin);
`ifdef CTRL_MEM_ARB_STATS_EN
      if (i == 11) chkw("stat_conflicts_after_6", 64'(stat_conflicts), 64'd6);
`endif
    end

    // Host read, then lock rises while it is in flight; ctrl served under lock.
    drive(1'b1, 1'b0, 9'h060, 64'h0, 1'b0, 1'b0, 9'h000, 64'h0, 1'b0);
    chk1("pre_lock_host_ready", bus.host_req_ready, 1'b1);
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 1'b0, 9'h050, 64'h0, (k == 4 || k == 5), 1'b0, 9'(9'h06C + k), 64'h0, 1'b1);
      $display("lock cycle %0d: hr=%0b cr=%0b we=%0b", k, bus.host_req_ready,
               bus.ctrl_req_ready, bus.mem_we);
      chk1($sformatf("lock%0d_host_ready", k), bus.host_req_ready, 1'b0);
      chk1($sformatf("lock%0d_mem_we", k), bus.mem_we, 1'b0);
      chk1($sformatf("lock%0d_ctrl_ready", k), bus.ctrl_req_ready, (k == 4 || k == 5));
    end
    drive(1'b1, 1'b0, 9'h050, 64'h0, 1'b0, 1'b0, 9'h000, 64'h0, 1'b0);
    chk1("unlock_host_ready", bus.host_req_ready, 1'b1);
    chkw("unlock_mem_addr", 64'(bus.mem_addr), 64'h050);
    idle();
`ifdef CTRL_MEM_ARB_STATS_EN
    chkw("stat_conflicts_after_lock", 64'(stat_conflicts), 64'd9);
    chkw("stat_host_stall_after_lock", 64'(stat_host_stall), 64'd13);
`endif

    // Ctrl write then read of the top address.
    drive(1'b0, 1'b0, 9'h000, 64'h0, 1'b1, 1'b1, 9'h1FF, DB, 1'b0);
    chk1("top_wr_ctrl_ready", bus.ctrl_req_ready, 1'b1);
    chk1("top_wr_mem_we", bus.mem_we, 1'b1);
    chkw("top_wr_mem_addr", 64'(bus.mem_addr), 64'h1FF);
    drive(1'b0, 1'b0, 9'h000, 64'h0, 1'b1, 1'b0, 9'h1FF, 64'h0, 1'b0);
    chk1("top_rd_ctrl_ready", bus.ctrl_req_ready, 1'b1);
    chk1("top_rd_mem_we", bus.mem_we, 1'b0);
    idle();
    idle();
    idle();
    chk1("top_rd_rsp_valid", bus.ctrl_rsp_valid, 1'b1);
    chkw("top_rd_rdata", bus.ctrl_rsp_rdata, DB);
    chk1("top_rd_host_rsp_valid", bus.host_rsp_valid, 1'b0);
    idle();
    chk1("top_rd_rsp_pulse_end", bus.ctrl_rsp_valid, 1'b0);
    chkw("top_rd_rdata_hold", bus.ctrl_rsp_rdata, DB);

    // Three back-to-back host reads, reset one cycle after the last accept.
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b0, 9'(9'h010 + k), 64'h0, 1'b0, 1'b0, 9'h000, 64'h0, 1'b0);
      chk1($sformatf("b2b%0d_host_ready", k), bus.host_req_ready, 1'b1);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.host_req_valid = 1'b1; bus.host_req_we = 1'b1; bus.host_req_addr = 9'h011;
    bus.ctrl_req_valid = 1'b1; bus.ctrl_req_we = 1'b1; bus.ctrl_req_addr = 9'h022;
    @(negedge clk);
    chk_reset_outputs("mid_reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.host_req_we = 1'b0;
    bus.ctrl_req_we = 1'b0;
    @(negedge clk);
    chk1("post_reset_host_ready", bus.host_req_ready, 1'b1);
    chk1("post_reset_ctrl_ready", bus.ctrl_req_ready, 1'b0);
    chk1("post_reset_host_rsp", bus.host_rsp_valid, 1'b0);
    chkw("post_reset_host_rdata", bus.host_rsp_rdata, 64'h0);
    chkw("post_reset_ctrl_rdata", bus.ctrl_rsp_rdata, 64'h0);
`ifdef CTRL_MEM_ARB_STATS_EN
    chkw("post_reset_stat_conflicts", 64'(stat_conflicts), 64'd0);
    chkw("post_reset_stat_host_stall", 64'(stat_host_stall), 64'd0);
`endif
    idle();
    chk1("post_reset_flushed_rsp", bus.host_rsp_valid, 1'b0);

    // Drain remaining responses within a bounded number of cycles.
    for (int k = 0; k < 20 && sb_q.size() > 0; k++) idle();
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d responses outstanding expected 0", sb_q.size());
    end
    repeat (4) idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ctrl_mem_arbiter.md
Name: ctrl_mem_arbiter

Overview:
Shares the single-port 64-bit control memory between two requesters: the host bridge (config/result register access) and speed_test_controller (config fetch, result write-back).
Valid/ready request handshake per requester, round-robin arbitration on conflict, and a controller lock for atomic multi-word sequences.
Read data returns on a fixed-latency, tagged response path.
Sits between the requesters and the BRAM port.

Parameters:
MEM_ADDR_WIDTH, 9, control memory word address width
MEM_READ_LATENCY, 2, cycles from mem_addr presented to mem_dout valid (1..4)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
host_req_valid  in  1  host request valid
host_req_ready  out  1  host request accepted this cycle
host_req_we  in  1  1=write, 0=read
host_req_addr  in  MEM_ADDR_WIDTH  word address
host_req_wdata  in  64  write data
host_rsp_valid  out  1  host read data valid (single-cycle pulse)
host_rsp_rdata  out  64  host read data
ctrl_req_valid / ctrl_req_ready / ctrl_req_we / ctrl_req_addr / ctrl_req_wdata  as host_*, for controller
ctrl_rsp_valid  out  1  controller read data valid
ctrl_rsp_rdata  out  64  controller read data
ctrl_lock  in  1  while high, host is never granted
mem_we  out  1  memory write enable
mem_addr  out  MEM_ADDR_WIDTH  memory address
mem_din  out  64  memory write data
mem_dout  in  64  memory read data

Behaviour:
- Reset: all *_req_ready=0, *_rsp_valid=0, *_rsp_rdata=0, mem_we=0, mem_addr=0, mem_din=0.
- Reset also clears the tag pipeline; reads in flight at reset produce no response.
- rr_last resets to CTRL.
- Grant is combinational each cycle, at most one grant per cycle:
  - Only one requester valid: that requester is granted, subject to the lock rule.
  - Both valid, ctrl_lock=0: grant the requester not equal to rr_last.
  - ctrl_lock=1: host_req_ready=0; ctrl is granted whenever ctrl_req_valid.
- Accept = valid & ready.
- rr_last updates to the accepted requester at the clock edge; unchanged if nothing is accepted.
- Memory drive:
  - mem_addr/mem_din mux from the granted requester.
  - mem_we = accepted & we.
  - With no grant: mem_we=0; mem_addr/mem_din hold their previous values.
- Requesters must hold addr/we/wdata stable while valid and not ready.
- Read response:
  - Each accepted read pushes tag {valid, requester} into a MEM_READ_LATENCY-deep shift register.
  - When the tag emerges, raise the matching *_rsp_valid for exactly one cycle.
  - *_rsp_rdata is registered (capture mem_dout in that cycle), so response latency = MEM_READ_LATENCY+1 cycles after accept.
  - rdata holds its value between responses.
  - No response backpressure: requesters must always sink responses.
  - Back-to-back reads are fully pipelined, one per cycle.
- Writes produce no response.
- Read after write to the same address, accepted in consecutive cycles: the read returns the new data (BRAM write-first mode is required of the memory).
- Lock timing:
  - ctrl_lock rising while a host read is in flight does not cancel it; its response still returns.
  - ctrl_lock takes effect in the same cycle it rises.

Optional Feature:
CTRL_MEM_ARB_STATS_EN: adds outputs stat_conflicts (32b) and stat_host_stall (32b).
- stat_conflicts increments on each cycle both requesters are valid.
- stat_host_stall increments on each cycle host_req_valid & !host_req_ready.
- Both counters saturate at 0xFFFFFFFF and reset to 0.
- Without the macro the ports and counters are absent and arbitration is identical.

Test Plan:
1. After reset, host reads addr 0x010 holding 0x1122334455667788 (ctrl idle) -> host_req_ready same cycle; host_rsp_valid one pulse 3 cycles after accept with that data; ctrl_rsp_valid stays 0.
2. Both valid every cycle for 6 cycles, lock=0 -> grants host,ctrl,host,ctrl,host,ctrl; stat_conflicts=6 if enabled.
3. ctrl_lock=1 for 10 cycles with host valid and ctrl idle -> host_req_ready=0 throughout, mem_we=0; host granted the cycle after lock drops; stat_host_stall=10.
4. Ctrl writes 0xDEADBEEF to 0x1FF, then reads 0x1FF next cycle -> ctrl_rsp_rdata=0xDEADBEEF; address wrap max value handled.
5. Host issues 3 back-to-back reads, rst asserted 1 cycle after the last accept -> no rsp_valid pulses; all outputs at reset values; first post-reset conflict grants host.
